fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be as follows:
- DATA_WIDTH, default 16, instruction word width.
- ADDR_WIDTH, default 8, program-memory word address width.
- RESET_VECTOR, default 0, first fetch address after reset.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- rom_addr, out, ADDR_WIDTH: program counter driven to the program ROM.
- rom_data, in, DATA_WIDTH: ROM word; the value sampled at a rising edge belongs to the rom_addr held during the preceding cycle (the ROM registers on the falling edge).
- stall, in, 1: downstream not ready; meaningful only while instr_valid=1.
- redirect, in, 1: branch/jump taken; load a new PC.
- redirect_pc, in, ADDR_WIDTH: target address, sampled when redirect=1.
- instr, out, DATA_WIDTH: first instruction word.
- instr_ext, out, DATA_WIDTH: second word of a two-word instruction, else 0.
- instr_pc, out, ADDR_WIDTH: address of instr.
- instr_two_word, out, 1: instr_ext is valid.
- instr_valid, out, 1: output bundle valid.

Function
REQ-003 rom_addr SHALL equal the internal pc register, with no combinational path from any input.
REQ-004 A consume event SHALL be an edge with instr_valid=1 and stall=0; the output slot is free when instr_valid=0 or a consume event occurs.
REQ-005 The FSM SHALL have two states: FETCH1 (awaiting first word) and FETCH2 (awaiting extension word).
REQ-006 Two-word opcodes SHALL be the following masks on rom_data:
- LDS: 1001_000x_xxxx_0000.
- STS: 1001_001x_xxxx_0000.
- JMP: 1001_010x_xxxx_110x.
- CALL: 1001_010x_xxxx_111x.
REQ-007 In FETCH1 with the slot free and the word single-word:
- instr<=rom_data, instr_pc<=pc, instr_ext<=0, instr_two_word<=0, instr_valid<=1.
- pc<=pc+1; stay in FETCH1.
REQ-008 In FETCH1 with the slot free and the word two-word:
- instr<=rom_data, instr_pc<=pc, instr_valid<=0.
- pc<=pc+1; go to FETCH2.
REQ-009 In FETCH2:
- instr_ext<=rom_data, instr_two_word<=1, instr_valid<=1.
- pc<=pc+1; go to FETCH1.
REQ-010 With instr_valid=1 and stall=1 (no redirect), pc, state and all instr_* outputs SHALL hold.
REQ-011 Steady-state throughput SHALL be one single-word instruction per cycle with stall=0; a two-word instruction SHALL take two cycles.
REQ-012 redirect=1 SHALL override stall and the FSM:
- pc<=redirect_pc, instr_valid<=0, state<=FETCH1.
- The rom_data sampled at that edge is discarded.
- The target word is captured at the following edge (exactly one bubble).
REQ-013 redirect during FETCH2 SHALL abandon the partial two-word instruction; it is never presented.
REQ-014 pc SHALL increment modulo 2^ADDR_WIDTH:
- After the last address, the next fetch is address 0.
- A two-word instruction at the last address takes its extension word from address 0.
REQ-015 redirect and stall asserted together SHALL behave as redirect alone.

Reset
REQ-016 When rst_n=0 at a rising edge, the following SHALL apply regardless of other inputs:
- pc<=RESET_VECTOR, state<=FETCH1.
- instr_valid<=0, instr_two_word<=0, instr<=0, instr_ext<=0, instr_pc<=0.
REQ-017 rom_addr SHALL read RESET_VECTOR throughout reset, so the first edge after release captures a valid word (reset held at least 1 cycle).
REQ-018 Reset asserted mid-two-word fetch or during a stall SHALL discard all in-flight state.

Verification
REQ-019 Reset release, ROM[0]=0xE003, ROM[1]=0xBB09, stall=0 -> edge 1: instr=0xE003, instr_pc=0, valid=1; edge 2: instr=0xBB09, instr_pc=1; rom_addr=2.
REQ-020 ROM[2]=0x9100, ROM[3]=0x0060 -> valid=0 for one cycle, then instr=0x9100, instr_ext=0x0060, instr_two_word=1, instr_pc=2, valid=1.
REQ-021 stall=1 for 3 cycles while instr=0xBB09 valid -> outputs and rom_addr=2 frozen; first edge after stall=0 presents ROM[2].
REQ-022 redirect=1, redirect_pc=0x40, with stall=1, in FETCH2 -> next edge valid=0, rom_addr=0x40; following edge instr_pc=0x40, valid=1; partial instruction never presented.
REQ-023 pc=0xFF holding 0x940C (JMP), ROM[0]=0x0010 -> instr=0x940C, instr_ext=0x0010, instr_pc=0xFF; rom_addr=0x01 afterwards.
REQ-024 rst_n=0 for 1 cycle during FETCH2 with stall=1 -> all outputs 0, rom_addr=RESET_VECTOR; refetch from address 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a program ROM with a registered read and assembles
// one- and two-word instructions into an output bundle, with stall and redirect.
module fetch_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_ext,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_two_word,
  output logic                  instr_valid
);

  // Handshake: the bundle transfers on a rising edge where instr_valid=1 and
  // stall=0; stall is ignored while instr_valid=0, and redirect overrides both.
  typedef enum logic {FETCH1, FETCH2} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc, pc_next;
  logic [DATA_WIDTH-1:0]   instr_next, ext_next;
  logic [ADDR_WIDTH-1:0]   ipc_next;
  logic                    two_next, valid_next;
  logic                    slot_free;
  logic                    is_two_word;
  logic [15:0]             opcode;

  assign rom_addr  = pc;
  assign slot_free = !instr_valid || !stall;
  assign opcode    = rom_data[15:0];

  // LDS, STS, JMP and CALL carry a second address/immediate word.
  always_comb begin
    is_two_word = 1'b0;
    casez (opcode)
      16'b1001_000?_????_0000: is_two_word = 1'b1;
      16'b1001_001?_????_0000: is_two_word = 1'b1;
      16'b1001_010?_????_110?: is_two_word = 1'b1;
      16'b1001_010?_????_111?: is_two_word = 1'b1;
      default:                 is_two_word = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    ext_next   = instr_ext;
    ipc_next   = instr_pc;
    two_next   = instr_two_word;
    valid_next = instr_valid;
    if (redirect) begin
      // The word arriving this edge belongs to the old path and is dropped.
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      state_next = FETCH1;
    end else begin
      case (state)
        FETCH1: begin
          if (slot_free) begin
            instr_next = rom_data;
            ipc_next   = pc;
            pc_next    = pc + ADDR_WIDTH'(1);
            if (is_two_word) begin
              valid_next = 1'b0;
              state_next = FETCH2;
            end else begin
              ext_next   = '0;
              two_next   = 1'b0;
              valid_next = 1'b1;
            end
          end
        end
        FETCH2: begin
          ext_next   = rom_data;
          two_next   = 1'b1;
          valid_next = 1'b1;
          pc_next    = pc + ADDR_WIDTH'(1);
          state_next = FETCH1;
        end
        default: state_next = FETCH1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FETCH1;
      pc             <= RESET_VECTOR;
      instr          <= '0;
      instr_ext      <= '0;
      instr_pc       <= '0;
      instr_two_word <= 1'b0;
      instr_valid    <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      instr          <= instr_next;
      instr_ext      <= ext_next;
      instr_pc       <= ipc_next;
      instr_two_word <= two_next;
      instr_valid    <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: falling-edge ROM model, program-order scoreboard of
// expected bundles, and directed checks for stall, redirect, wrap and reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic [7:0]  instr_pc;
  logic        instr_two_word;
  logic        instr_valid;

  logic [15:0] rom [256];
  logic [40:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_ext(instr_ext), .instr_pc(instr_pc),
    .instr_two_word(instr_two_word), .instr_valid(instr_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ROM registers the address on the falling edge
  always @(negedge clk) rom_data <= rom[rom_addr];

  function automatic logic [40:0] pack(input logic [7:0] pc, input logic two,
                                       input logic [15:0] w, input logic [15:0] e);
    return {pc, two, w, e};
  endfunction

  function automatic bit is_two(input logic [15:0] w);
    casez (w)
      16'b1001_000?_????_0000, 16'b1001_001?_????_0000,
      16'b1001_010?_????_110?, 16'b1001_010?_????_111?: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the next n instructions in program order starting at start.
  task automatic expect_run(input logic [7:0] start, input int n);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] w;
    a = start;
    for (int k = 0; k < n; k++) begin
      w = rom[a];
      b = a + 8'd1;
      if (is_two(w)) begin
        exp_q.push_back(pack(a, 1'b1, w, rom[b]));
        a = a + 8'd2;
      end else begin
        exp_q.push_back(pack(a, 1'b0, w, 16'h0000));
        a = b;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: a bundle visible with stall=0 is consumed at the next edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && stall === 1'b0 && redirect === 1'b0) begin
      if (exp_q.size() == 0)
        check("unexpected_bundle", {23'd0, pack(instr_pc, instr_two_word, instr, instr_ext)}, 64'hDEAD);
      else
        check("bundle", {23'd0, pack(instr_pc, instr_two_word, instr, instr_ext)},
              {23'd0, exp_q.pop_front()});
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(0, 16'h7FFF));
    rom[0] = 16'hE003;  rom[1] = 16'hBB09;  rom[2] = 16'h9100;  rom[3] = 16'h0060;
    rom[4] = 16'h1234;  rom[5] = 16'h940E;  rom[6] = 16'h0777;
    rom[8'h40] = 16'h2222; rom[8'h41] = 16'h9000; rom[8'h42] = 16'h0ABC;
    rom[8'h43] = 16'h9200; rom[8'h44] = 16'h0DEF; rom[8'h45] = 16'h9400;
    rom[8'h46] = 16'h9401; rom[8'h47] = 16'h9008; rom[8'h48] = 16'h9600;
    rom[8'h49] = 16'h940F; rom[8'h4A] = 16'h0123; rom[8'hFF] = 16'h940C;

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    check("reset_bundle", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)}, 64'd0);
    check("reset_rom_addr", {56'd0, rom_addr}, 64'h00);

    rst_n = 1'b1;
    expect_run(8'h00, 4);
    tick();
    check("first_instr", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)},
          {22'd0, 1'b1, pack(8'h00, 1'b0, 16'hE003, 16'h0000)});
    tick();
    check("second_instr", {instr_valid, instr_pc, instr}, {1'b1, 8'h01, 16'hBB09});
    check("second_rom_addr", {56'd0, rom_addr}, 64'h02);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)},
            {22'd0, 1'b1, pack(8'h01, 1'b0, 16'hBB09, 16'h0000)});
      check("stall_rom_addr", {56'd0, rom_addr}, 64'h02);
    end
    stall = 1'b0;
    tick();
    check("two_word_bubble", {instr_valid, instr, rom_addr}, {1'b0, 16'h9100, 8'h03});
    tick();
    check("two_word_lds", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)},
          {22'd0, 1'b1, pack(8'h02, 1'b1, 16'h9100, 16'h0060)});
    tick();
    tick();
    check("call_in_fetch2", {63'd0, instr_valid}, 64'd0);

    redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
    exp_q.delete();
    tick();
    check("redirect_bubble", {instr_valid, rom_addr}, {1'b0, 8'h40});
    redirect = 1'b0; stall = 1'b0;
    expect_run(8'h40, 40);
    tick();
    check("redirect_target", {instr_valid, instr_pc, instr}, {1'b1, 8'h40, 16'h2222});

    for (int i = 0; i < 30; i++) begin
      stall = 1'($urandom_range(0, 1));
      tick();
    end

    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'hFF; rom[0] = 16'h0010;
    exp_q.delete();
    tick();
    check("redirect_ff", {instr_valid, rom_addr}, {1'b0, 8'hFF});
    redirect = 1'b0; stall = 1'b0;
    expect_run(8'hFF, 3);
    tick();
    check("wrap_fetch2", {instr_valid, rom_addr}, {1'b0, 8'h00});
    tick();
    check("wrap_jmp", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)},
          {22'd0, 1'b1, pack(8'hFF, 1'b1, 16'h940C, 16'h0010)});
    check("wrap_rom_addr", {56'd0, rom_addr}, 64'h01);
    tick();
    tick();
    check("pre_reset_fetch2", {instr_valid, instr}, {1'b0, 16'h9100});

    rst_n = 1'b0; stall = 1'b1;
    exp_q.delete();
    tick();
    check("mid_reset_bundle", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)}, 64'd0);
    check("mid_reset_rom_addr", {56'd0, rom_addr}, 64'h00);
    rst_n = 1'b1; stall = 1'b0;
    expect_run(8'h00, 12);
    tick();
    check("refetch", {instr_valid, instr_pc, instr}, {1'b1, 8'h00, 16'h0010});
    repeat (8) tick();
    stall = 1'b1;
    tick();
    if (exp_q.size() == 0)
      check("final_queue", 64'd0, 64'd1);
    else
      check("final_bundle", {22'd0, instr_valid, pack(instr_pc, instr_two_word, instr, instr_ext)},
            {22'd0, 1'b1, exp_q[0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
